forest_sched: RTL
=================

Name: forest_sched

Overview:
Sequences one shared `tree` traversal engine across an ensemble of decision trees and produces one ensemble prediction per request.
- Sits between the host/ESP register interface and the tree engine.
- Selects the node-memory bank of the current tree and launches each tree walk.
- Collects each leaf value and accumulates a saturating signed sum, then reports completion.

Parameters:
- N_TREES, 16, maximum trees in the forest; node-memory banks are selected by tree_sel.
- TIMEOUT_CYCLES, 4096, watchdog limit per tree walk (used only when FOREST_TIMEOUT_EN is defined).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- n_trees  in  $clog2(N_TREES)+1  trees to evaluate; sampled with start
- abort  in  1  synchronous cancel of the current request
- busy  out  1  high from the cycle after accepted start until done/abort
- done  out  1  one-cycle pulse, result valid
- result  out  32  signed saturated sum of leaf values; held until next accepted start
- error  out  1  watchdog fired on the last request (FOREST_TIMEOUT_EN only, else tied 0)
- tree_start  out  1  one-cycle pulse to the tree engine
- tree_sel  out  $clog2(N_TREES)  node-memory bank of the current tree
- tree_done  in  1  one-cycle pulse from the tree engine
- tree_leaf  in  32  leaf value; valid in the cycle tree_done=1

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE, busy=0, done=0, result=0, error=0, tree_start=0, tree_sel=0, internal count=0, accumulator=0.
- States: IDLE, LAUNCH, WAIT, ACCUM, FINISH.
- IDLE:
  - On start=1: latch cnt = min(n_trees, N_TREES), clear the accumulator, clear error, set tree_sel=0, busy=1.
  - Next state is LAUNCH if cnt>0, else FINISH.
- LAUNCH: tree_start=1 for exactly one cycle; next state WAIT.
- WAIT:
  - Hold tree_sel stable.
  - On tree_done=1: capture tree_leaf; next state ACCUM.
  - tree_done in any other state is ignored.
- ACCUM:
  - acc = sat32(acc + leaf), computed in 33-bit signed arithmetic and clamped to [-2^31, 2^31-1].
  - If tree_sel == cnt-1: next state FINISH.
  - Otherwise: tree_sel+1, next state LAUNCH.
- FINISH: result<=acc, done=1 for one cycle, busy=0, next state IDLE.
- Per-tree latency: LAUNCH(1) + engine latency + ACCUM(1). n_trees=0 gives done 2 cycles after start, with result=0.
- start while busy is ignored; no queuing.
- abort=1 in any non-IDLE state:
  - Next cycle: IDLE, busy=0, no done pulse, result unchanged.
  - abort has priority over tree_done in the same cycle.
- abort in IDLE has no effect; start and abort together in IDLE: abort wins and start is dropped.
- tree_done arriving in the same cycle tree_start is asserted is not legal engine behaviour; it is ignored.

Optional Feature:
- Macro: FOREST_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT, reset on each entry to WAIT.
  - If it reaches TIMEOUT_CYCLES without tree_done: error<=1, go to FINISH, and done pulses with the partial sum.
  - error stays high until the next accepted start.
- Undefined: no counter; WAIT waits indefinitely; error tied 0.

Test Plan:
- n_trees=3, engine returns leaves 10, -4, 7 -> three tree_start pulses with tree_sel 0, 1, 2; one done pulse; result=13; busy low after done.
- n_trees=0 -> no tree_start; done 2 cycles after start; result=0.
- n_trees=2, leaves 0x7FFFFFF0 and 0x100 -> result=0x7FFFFFFF (positive saturation); leaves 0x80000000 and -1 -> result=0x80000000.
- Start with n_trees=4, abort in WAIT of tree 1 -> IDLE next cycle, no done, result keeps its previous value; a following start runs normally.
- n_trees=N_TREES+5 -> exactly N_TREES launches; second start during busy produces no extra launches.
- FOREST_TIMEOUT_EN, TIMEOUT_CYCLES=8, engine never responds on tree 0 -> done with error=1, result=0, after 8 WAIT cycles; rst_n asserted mid-WAIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/forest_sched.sv
// forest_sched: time-shares one tree traversal engine across an ensemble and returns
// the saturating signed sum of all leaf values. Define FOREST_TIMEOUT_EN for the per-walk watchdog.
module forest_sched #(
    parameter int N_TREES        = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [$clog2(N_TREES):0]   n_trees,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic [31:0]                result,
    output logic                       error,
    output logic                       tree_start,
    output logic [$clog2(N_TREES)-1:0] tree_sel,
    input  logic                       tree_done,
    input  logic [31:0]                tree_leaf
);
    localparam int SW = $clog2(N_TREES);
    localparam int CW = SW + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(N_TREES);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, ACCUM, FINISH} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic signed [31:0] acc;
    logic signed [31:0] leaf;
    logic signed [32:0] sum;
    logic signed [31:0] acc_sat;
    logic               last_tree;
    logic               accept;
    logic               wd_fire;

    assign accept    = (state == IDLE) && start && !abort;
    assign last_tree = ({1'b0, tree_sel} == cnt - CW'(1));
    assign sum       = {acc[31], acc} + {leaf[31], leaf};

    // NOTE: the default assignment comes first so every path drives acc_sat and no latch is inferred.
    always_comb begin
        acc_sat = sum[31:0];
        if (sum[32] != sum[31]) begin
            acc_sat = sum[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        end
    end

`ifdef FOREST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_cnt;

    // Held at zero outside WAIT, so each walk starts a fresh count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state != WAIT) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign wd_fire = (state == WAIT) && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error <= 1'b0;
        end else if (accept) begin
            error <= 1'b0;
        end else if (!abort && !tree_done && wd_fire) begin
            error <= 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
    assign error   = 1'b0;
`endif

    // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            tree_start <= 1'b0;
            tree_sel   <= '0;
            cnt        <= '0;
            acc        <= '0;
            leaf       <= '0;
        end else begin
            done       <= 1'b0;
            tree_start <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            cnt      <= (n_trees > MAX_CNT) ? MAX_CNT : n_trees;
                            acc      <= '0;
                            tree_sel <= '0;
                            busy     <= 1'b1;
                            // tree_start is registered, so it is high exactly while in LAUNCH.
                            if (n_trees != '0) begin
                                state      <= LAUNCH;
                                tree_start <= 1'b1;
                            end else begin
                                state <= FINISH;
                            end
                        end
                    end
                    LAUNCH: state <= WAIT;
                    WAIT: begin
                        if (tree_done) begin
                            leaf  <= tree_leaf;
                            state <= ACCUM;
                        end else if (wd_fire) begin
                            state <= FINISH;
                        end
                    end
                    ACCUM: begin
                        acc <= acc_sat;
                        if (last_tree) begin
                            state <= FINISH;
                        end else begin
                            tree_sel   <= tree_sel + 1'b1;
                            tree_start <= 1'b1;
                            state      <= LAUNCH;
                        end
                    end
                    FINISH: begin
                        result <= acc;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
